// File: rtl/adder32_flagged_pkg.sv
// adder32_flagged_pkg
// Shared constants and the flag bundle for the 32-bit flagged adder.
// flags_t is the same layout the ALU flag register stores.
package adder32_flagged_pkg;

  localparam int WORD_W     = 32;
  localparam int SLICE_W    = 4;
  localparam int NUM_SLICES = WORD_W / SLICE_W;

  typedef struct packed {
    logic of_f;  // signed overflow
    logic sf;    // sign
    logic zf;    // zero
    logic cf;    // carry
  } flags_t;

endpackage

// File: rtl/adder32_flagged_cla4_slice.sv
// cla4_slice
// 4-bit carry-lookahead adder slice, equivalent to one 74x283.
// Ports:
//   a, b  : 4-bit operands
//   cin   : carry into bit 0
//   s     : 4-bit sum
//   cout  : carry out of bit 3
//   c3    : carry into bit 3, used for overflow detection on the top slice
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead: every carry is a two-level function of g, p and cin.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/adder32_flagged.sv
// adder32_flagged
// 32-bit adder with carry-in, built from eight rippled 4-bit CLA slices.
// Sum, carry-out and flags are registered together (1-cycle latency).
// Ports:
//   clk  : clock, outputs update on rising edge
//   rst  : synchronous active-high reset, clears all outputs
//   A, B : 32-bit operands
//   Cin  : carry into bit 0
//   F    : registered sum A+B+Cin mod 2^32
//   Cout : registered carry out of bit 31
//   OF, SF, ZF, CF : registered overflow / sign / zero / carry flags
module adder32_flagged
  import adder32_flagged_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              Cin,
  output logic [WORD_W-1:0] F,
  output logic              Cout,
  output logic              OF,
  output logic              SF,
  output logic              ZF,
  output logic              CF
);

  logic [NUM_SLICES:0]   carry;
  logic [NUM_SLICES-1:0] c3_slice;
  logic [WORD_W-1:0]     sum;
  flags_t                flags_d;
  flags_t                flags_q;
  logic [WORD_W-1:0]     f_q;
  logic                  cout_q;

  assign carry[0] = Cin;

  for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
    cla4_slice u_slice (
      .a    (A[i*SLICE_W +: SLICE_W]),
      .b    (B[i*SLICE_W +: SLICE_W]),
      .cin  (carry[i]),
      .s    (sum[i*SLICE_W +: SLICE_W]),
      .cout (carry[i+1]),
      .c3   (c3_slice[i])
    );
  end

  // Top slice's c3 is the carry into bit 31; overflow is that XOR carry out.
  always_comb begin
    flags_d      = '0;
    flags_d.of_f = c3_slice[NUM_SLICES-1] ^ carry[NUM_SLICES];
    flags_d.sf   = sum[WORD_W-1];
    flags_d.zf   = (sum == '0);
    flags_d.cf   = carry[NUM_SLICES];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q     <= '0;
      cout_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      f_q     <= sum;
      cout_q  <= carry[NUM_SLICES];
      flags_q <= flags_d;
    end
  end

  assign F    = f_q;
  assign Cout = cout_q;
  assign OF   = flags_q.of_f;
  assign SF   = flags_q.sf;
  assign ZF   = flags_q.zf;
  assign CF   = flags_q.cf;

endmodule

// File: tb/tb_adder32_flagged.sv
// Bench for adder32_flagged: directed boundary cases with literal
// expectations, then randomized back-to-back traffic with mid-stream resets,
// all checked every cycle against a behavioural arithmetic model.
module tb_adder32_flagged;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A   = '0;
  logic [31:0] B   = '0;
  logic        Cin = 1'b0;
  logic [31:0] F;
  logic        Cout, OF, SF, ZF, CF;

  int n_checks = 0;
  int n_fail   = 0;

  // {F, Cout, OF, SF, ZF, CF}
  logic [36:0] exp_out   = '0;
  logic        exp_valid = 1'b0;

  always #5 clk = ~clk;

  adder32_flagged dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .F    (F),
    .Cout (Cout),
    .OF   (OF),
    .SF   (SF),
    .ZF   (ZF),
    .CF   (CF)
  );

  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [32:0] full;
    logic [31:0] f;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    f    = full[31:0];
    ov   = (a[31] == b[31]) && (f[31] != a[31]);
    return {f, full[32], ov, f[31], (f == 32'd0), full[32]};
  endfunction

  function automatic logic [36:0] dut_out();
    return {F, Cout, OF, SF, ZF, CF};
  endfunction

  // Reference: what the outputs must hold after each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_out   <= '0;
      exp_valid <= 1'b1;
    end else begin
      exp_out   <= model(A, B, Cin);
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_checks++;
      if (dut_out() !== exp_out) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got F=%h C=%b OF=%b SF=%b ZF=%b CF=%b want F=%h C=%b OF=%b SF=%b ZF=%b CF=%b",
                 $time, F, Cout, OF, SF, ZF, CF, exp_out[36:5], exp_out[4], exp_out[3],
                 exp_out[2], exp_out[1], exp_out[0]);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(posedge clk);
    #2;
    A   = a;
    B   = b;
    Cin = cin;
  endtask

  // Apply one op, then check the outputs after the next edge against a literal.
  task automatic lit(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic cin, input logic [36:0] want);
    drive(a, b, cin);
    @(posedge clk);
    #1;
    n_checks++;
    if (dut_out() !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, dut_out(), want);
    end
  endtask

  initial begin
    logic [31:0] pick [4];
    logic [31:0] a, b;
    pick[0] = 32'h0000_0000;
    pick[1] = 32'hffff_ffff;
    pick[2] = 32'h7fff_ffff;
    pick[3] = 32'h8000_0000;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_out() !== 37'd0) begin
      n_fail++;
      $display("FAIL reset got %h want 0", dut_out());
    end
    drive('0, '0, 1'b0);
    rst = 1'b0;

    //                                  F              Co OF SF ZF CF
    lit("pos_ovf_1",  32'h0000_0001, 32'h7fff_ffff, 1'b0, {32'h8000_0000, 5'b0_1_1_0_0});
    lit("no_flags",   32'h0a10_3012, 32'h0202_fc8b, 1'b0, {32'h0c13_2c9d, 5'b0_0_0_0_0});
    lit("carry_out",  32'hffff_ffff, 32'h0000_0010, 1'b0, {32'h0000_000f, 5'b1_0_0_0_1});
    lit("wrap_zero",  32'hff0f_0000, 32'h00f0_ffff, 1'b1, {32'h0000_0000, 5'b1_0_0_1_1});
    lit("ovf_cin",    32'h0fff_ffff, 32'h7fff_ffff, 1'b1, {32'h8fff_ffff, 5'b0_1_1_0_0});
    lit("neg_result", 32'h00bc_614e, 32'hff43_9eb0, 1'b1, {32'hffff_ffff, 5'b0_0_1_0_0});
    lit("full_wrap",  32'hffff_ffff, 32'h0000_0000, 1'b1, {32'h0000_0000, 5'b1_0_0_1_1});
    lit("pos_ovf_2",  32'h7fff_ffff, 32'h0000_0001, 1'b0, {32'h8000_0000, 5'b0_1_1_0_0});
    lit("neg_ovf",    32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 5'b1_1_0_1_1});
    lit("cin_only",   32'h0000_0000, 32'h0000_0000, 1'b1, {32'h0000_0001, 5'b0_0_0_0_0});

    // Random back-to-back traffic, one op per cycle, resets injected mid-stream.
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = -a;
      drive(a, b, 1'($urandom_range(0, 1)));
      rst = (i == 100) || (i == 101) || (i == 250);
    end
    drive('0, '0, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder32_flagged.md
Name: adder32_flagged

Overview:
- 32-bit binary adder with carry-in. Produces the sum plus a carry-out and four status flags (OF, SF, ZF, CF).
- Serves as the ALU add path feeding the processor flag register.
- Built from eight chained 4-bit carry-lookahead slices, each equivalent to a 74x283.
- Outputs are registered: one clock, synchronous active-high reset.

Parameters:
- None. Width is fixed at 32 bits, made of 8 slices of 4 bits.

Ports:
- clk  input  1  system clock; all outputs update on its rising edge
- rst  input  1  synchronous active-high reset
- A    input  32  operand A, two's complement or unsigned
- B    input  32  operand B
- Cin  input  1  carry-in into bit 0
- F    output 32  registered sum, A+B+Cin mod 2^32
- Cout output 1  registered carry out of bit 31
- OF   output 1  registered signed-overflow flag
- SF   output 1  registered sign flag
- ZF   output 1  registered zero flag
- CF   output 1  registered carry flag

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset:
  - When rst=1 at a rising edge, F=0, Cout=0, OF=0, SF=0, ZF=0 and CF=0 on the next cycle.
  - ZF is 0 after reset; it is not derived from F=0.
  - rst has priority over the operands.
- Latency is 1 cycle:
  - A, B and Cin sampled at rising edge N appear on F and the flags after edge N.
  - No handshake. A new operation is accepted every cycle, and outputs hold between edges.
- Arithmetic: the 33-bit result {Cout,F} = A + B + Cin, unsigned.
- Carry path:
  - Each 4-bit slice i computes generate Gi = A&B and propagate Pi = A^B, then does lookahead within the slice.
  - Slices are rippled: slice i carry-in is slice i-1 carry-out, and slice 0 carry-in is Cin.
- Flags, all computed from the same combinational result and registered together:
  - OF = (A[31]==B[31]) && (F[31]!=A[31]), i.e. carry into bit 31 XOR carry out of bit 31.
  - SF = F[31].
  - ZF = (F==32'h0).
  - CF = Cout. The two are always identical; CF is the flag-register copy.
- Boundary cases:
  - Full wrap: ffffffff+0+1 gives F=0, Cout=1, ZF=1.
  - Positive overflow: 7fffffff+1 gives OF=1.
  - Negative overflow: 80000000+80000000 gives F=0, OF=1, CF=1, ZF=1.
  - Cin=1 with A=B=0 gives F=1.
- No X propagation is tolerated: every output is driven from flops at all times after the first reset.

Decomposition:
- Shared package: constant WORD_W=32, constant SLICE_W=4, and a flags struct {OF,SF,ZF,CF} reused by the ALU flag register.
- One natural sub-module, cla4_slice:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout, plus c3 (carry into bit 3) for overflow detection on the top slice.
  - Instantiated 8 times in a generate loop.
- The top level holds the flag logic and the output registers.

Test Plan:
- rst=1 for 2 cycles, then check -> all outputs 0. Release rst and apply A=00000001, B=7fffffff, Cin=0 -> next cycle F=80000000, Cout=0, OF=1, SF=1, ZF=0, CF=0.
- A=0a103012, B=0202fc8b, Cin=0 -> F=0c132c9d, all flags 0.
- A=ffffffff, B=00000010, Cin=0 -> F=0000000f, Cout=1, CF=1, OF=0, SF=0, ZF=0.
- A=ff0f0000, B=00f0ffff, Cin=1 -> F=00000000, Cout=1, CF=1, ZF=1, OF=0, SF=0.
- A=0fffffff, B=7fffffff, Cin=1 -> F=8fffffff, OF=1, SF=1, Cout=0. Then A=00bc614e (12345678), B=ff439eb0 (-12345680), Cin=1 -> F=ffffffff, SF=1, OF=0, Cout=0, ZF=0.
- Back-to-back ops each cycle, with rst asserted mid-stream -> outputs are 0 the cycle after the rst edge, the pipeline resumes correctly, and the 1-cycle latency is preserved.
